// File: rtl/cosine_lut_arbiter.sv
// Round-robin arbiter sharing one single-read-port cosine ROM between REQUESTERS channels.
// Per-channel grant counters are built only when COSINE_LUT_ARB_STATS_EN is defined.
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 64
`endif
`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 16
`endif

module cosine_lut_arbiter #(
  parameter int REQUESTERS  = 3,
  parameter int ANGLE_WIDTH = $clog2(`CARRIER_SAMPLES_PER_PERIOD),
  parameter int DATA_WIDTH  = `FIXDT_64_A_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REQUESTERS-1:0]             req_valid,
  input  logic [REQUESTERS*ANGLE_WIDTH-1:0] req_angle,
  output logic [REQUESTERS-1:0]             req_ready,
  output logic [REQUESTERS-1:0]             rsp_valid,
  output logic [REQUESTERS*DATA_WIDTH-1:0]  rsp_data,
  output logic                              rom_en,
  output logic [ANGLE_WIDTH-1:0]            rom_addr,
  input  logic signed [DATA_WIDTH-1:0]      rom_data,
  input  logic                              stats_clr,
  output logic [REQUESTERS*16-1:0]          grant_count
);
  localparam int PTR_W = $clog2(REQUESTERS);
  typedef logic [PTR_W-1:0] idx_t;

  idx_t                         ptr;
  idx_t                         gnt_idx;
  idx_t                         tag_a;
  idx_t                         tag_b;
  logic                         gnt_any;
  logic                         accept;
  logic                         vld_b;
  logic [ANGLE_WIDTH-1:0]       gnt_angle;
  logic signed [DATA_WIDTH-1:0] rsp_q [REQUESTERS];

  function automatic idx_t rr_idx(input idx_t base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= REQUESTERS) s = s - REQUESTERS;
    return idx_t'(s);
  endfunction

  // First valid channel at or after ptr, with wrap-around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (!gnt_any && req_valid[rr_idx(ptr, i)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx(ptr, i);
      end
    end
  end

  assign gnt_angle = req_angle[int'(gnt_idx)*ANGLE_WIDTH +: ANGLE_WIDTH];
  assign accept    = rst_n & gnt_any;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // Stage A drives the ROM, stage B aligns the tag with rom_data, stage C loads the channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      tag_a     <= '0;
      vld_b     <= 1'b0;
      tag_b     <= '0;
      rsp_valid <= '0;
      for (int k = 0; k < REQUESTERS; k++) rsp_q[k] <= '0;
    end else begin
      rom_en <= accept;
      if (accept) begin
        rom_addr <= gnt_angle;
        tag_a    <= gnt_idx;
        ptr      <= (gnt_idx == idx_t'(REQUESTERS-1)) ? '0 : gnt_idx + 1'b1;
      end
      vld_b     <= rom_en;
      tag_b     <= tag_a;
      rsp_valid <= '0;
      if (vld_b) begin
        rsp_valid[tag_b] <= 1'b1;
        rsp_q[tag_b]     <= rom_data;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < REQUESTERS; g++) begin : g_rsp
      assign rsp_data[g*DATA_WIDTH +: DATA_WIDTH] = rsp_q[g];
    end
  endgenerate

`ifdef COSINE_LUT_ARB_STATS_EN
  logic [15:0] cnt [REQUESTERS];

  // Clear wins over a same-cycle increment; counts saturate.
  always_ff @(posedge clk) begin
    for (int k = 0; k < REQUESTERS; k++) begin
      if (!rst_n || stats_clr) begin
        cnt[k] <= '0;
      end else if (accept && gnt_idx == idx_t'(k) && cnt[k] != 16'hFFFF) begin
        cnt[k] <= cnt[k] + 16'd1;
      end
    end
  end

  generate
    for (g = 0; g < REQUESTERS; g++) begin : g_cnt
      assign grant_count[g*16 +: 16] = cnt[g];
    end
  endgenerate
`else
  logic unused_stats;
  assign unused_stats = stats_clr;
  assign grant_count  = '0;
`endif

endmodule

// File: tb/tb_cosine_lut_arbiter.sv
// Bench for cosine_lut_arbiter: queued requesters, a behavioural ROM, a round-robin/latency
// model compared on every falling edge, and directed literal checks of the same behaviour.
module tb_cosine_lut_arbiter;
  localparam int R  = 3;
  localparam int AW = 6;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [R-1:0]      req_valid = '0;
  logic [R*AW-1:0]   req_angle = '0;
  logic [R-1:0]      req_ready;
  logic [R-1:0]      rsp_valid;
  logic [R*DW-1:0]   rsp_data;
  logic              rom_en;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data = '0;
  logic              stats_clr = 1'b0;
  logic [R*16-1:0]   grant_count;

  cosine_lut_arbiter #(.REQUESTERS(R), .ANGLE_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .stats_clr(stats_clr), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Table contents are arbitrary but distinct; only the address-to-data mapping matters.
  function automatic logic [15:0] cos_lut(input int a);
    int v;
    v = (a * 1021 + 4951) % 65536;
    return v[15:0];
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= cos_lut(int'(rom_addr));

  // Requesters: each channel presents the head of its queue until the model says it was taken.
  int   q[R][$];
  logic m_acc = 1'b0;
  int   m_grant = 0;
  int   wait_cnt[R];
  bit   track[R];
  int   max_wait = 0;

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < R; k++) begin
      if (req_valid[k]) begin
        if (m_acc && m_grant == k) begin
          if (track[k] && wait_cnt[k] + 1 > max_wait) max_wait = wait_cnt[k] + 1;
          wait_cnt[k] = 0;
          if (q[k].size() > 0) void'(q[k].pop_front());
        end else begin
          wait_cnt[k]++;
        end
      end
    end
    for (int k = 0; k < R; k++) begin
      req_valid[k] = (q[k].size() > 0);
      if (q[k].size() > 0) req_angle[k*AW +: AW] = AW'(q[k][0]);
    end
  end

  // Model: round-robin choice from a pointer, lookups emerge as responses 3 cycles later.
  typedef struct { int cyc; int ch; int ang; } pend_t;
  pend_t         pend[$];
  int            cyc = 0;
  bit            chk_en = 1'b0;
  int            m_ptr = 0;
  logic          m_rom_en = 1'b0;
  logic [AW-1:0] m_rom_addr = '0;
  logic [R-1:0]  m_rsp_valid = '0;
  logic [DW-1:0] m_rsp[R];
  int            m_gc[R];

  always @(negedge clk) begin
    logic [R-1:0] e_ready;
    pend_t        p;
    int           ang;
    e_ready = '0;
    m_acc   = 1'b0;
    m_grant = 0;
    if (rst_n === 1'b1) begin
      for (int i = 0; i < R; i++) begin
        if (!m_acc && req_valid[(m_ptr + i) % R]) begin
          m_acc   = 1'b1;
          m_grant = (m_ptr + i) % R;
        end
      end
      if (m_acc) e_ready[m_grant] = 1'b1;
    end
    if (chk_en) begin
      check("req_ready", 64'(req_ready), 64'(e_ready));
      check("rom_en", 64'(rom_en), 64'(m_rom_en));
      check("rom_addr", 64'(rom_addr), 64'(m_rom_addr));
      check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
      for (int k = 0; k < R; k++) begin
        check($sformatf("rsp_data[%0d]", k), 64'(rsp_data[k*DW +: DW]), 64'(m_rsp[k]));
        check($sformatf("grant_count[%0d]", k), 64'(grant_count[k*16 +: 16]), 64'(m_gc[k]));
      end
    end
    if (rst_n !== 1'b1) begin
      m_ptr       = 0;
      m_rom_en    = 1'b0;
      m_rom_addr  = '0;
      m_rsp_valid = '0;
      for (int k = 0; k < R; k++) begin
        m_rsp[k] = '0;
        m_gc[k]  = 0;
      end
      pend.delete();
      chk_en = 1'b1;
    end else begin
      m_rsp_valid = '0;
      if (pend.size() > 0 && pend[0].cyc == cyc - 2) begin
        p = pend.pop_front();
        m_rsp_valid[p.ch] = 1'b1;
        m_rsp[p.ch] = cos_lut(p.ang);
      end
      m_rom_en = m_acc;
      if (m_acc) begin
        ang        = int'(req_angle[m_grant*AW +: AW]);
        m_rom_addr = AW'(ang);
        pend.push_back('{cyc, m_grant, ang});
        m_ptr = (m_grant + 1) % R;
      end
`ifdef COSINE_LUT_ARB_STATS_EN
      for (int k = 0; k < R; k++) begin
        if (stats_clr) m_gc[k] = 0;
        else if (m_acc && m_grant == k && m_gc[k] < 65535) m_gc[k]++;
      end
`endif
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit busy();
    int n;
    n = 0;
    for (int k = 0; k < R; k++) n += q[k].size();
    return n != 0;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    check("drain_queues", 64'(busy()), 64'(0));
    repeat (5) tick();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [R-1:0] exp_g [6];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int k = 0; k < R; k++) begin
      wait_cnt[k] = 0;
      track[k]    = 1'b0;
    end

    repeat (3) @(posedge clk);
    #2;
    check("reset_rsp_data", 64'(rsp_data), 64'(0));
    check("reset_rom_en", 64'(rom_en), 64'(0));
    rst_n = 1'b1;

    // Single channel streaming.
    for (int i = 0; i < 20; i++) q[0].push_back(i);
    tick();
    tick();
    check("t1_rom_en", 64'(rom_en), 64'(1));
    check("t1_rom_addr", 64'(rom_addr), 64'(0));
    tick();
    tick();
    check("t1_rsp_valid", 64'(rsp_valid), 64'(3'b001));
    check("t1_rsp0_first", 64'(rsp_data[15:0]), 64'(16'h1357));
    tick();
    check("t1_rsp0_second", 64'(rsp_data[15:0]), 64'(16'h1754));
    check("t1_others_zero", 64'(rsp_data[47:16]), 64'(0));
    drain(200);

    // All channels contending from a fresh pointer.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < R; k++) q[k].push_back(k * 10 + i);
    for (int j = 0; j < 6; j++) begin
      tick();
      check($sformatf("t2_grant_%0d", j), 64'(req_ready), 64'(exp_g[j]));
    end
    drain(200);

    // Angle wrap-around on ch2.
    q[2].push_back(63);
    q[2].push_back(0);
    tick();
    tick();
    check("t3_addr_max", 64'(rom_addr), 64'(6'd63));
    tick();
    check("t3_addr_zero", 64'(rom_addr), 64'(0));
    tick();
    check("t3_rsp_valid", 64'(rsp_valid), 64'(3'b100));
    check("t3_rsp2_max", 64'(rsp_data[47:32]), 64'(16'h0E9A));
    tick();
    check("t3_rsp2_zero", 64'(rsp_data[47:32]), 64'(16'h1357));
    drain(200);

    // Reset one cycle after an acceptance on ch1.
    q[1].push_back(7);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q[0].push_back(1);
    q[1].push_back(2);
    q[2].push_back(3);
    tick();
    check("t4_no_rsp", 64'(rsp_valid), 64'(0));
    check("t4_rom_en", 64'(rom_en), 64'(0));
    check("t4_rsp_cleared", 64'(rsp_data), 64'(0));
    check("t4_ch0_wins", 64'(req_ready), 64'(3'b001));
    drain(200);

    // Held data on ch1 while ch0 and ch2 contend.
    q[1].push_back(5);
    repeat (6) tick();
    check("t5_rsp1_loaded", 64'(rsp_data[31:16]), 64'(16'h2748));
    max_wait = 0;
    track[0] = 1'b1;
    track[2] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      q[0].push_back(i);
      q[2].push_back(63 - i);
    end
    repeat (100) tick();
    check("t5_rsp1_held", 64'(rsp_data[31:16]), 64'(16'h2748));
    check("t5_max_wait_within_3", 64'(max_wait <= 3 && max_wait >= 1), 64'(1));
    track[0] = 1'b0;
    track[2] = 1'b0;
    drain(200);

`ifdef COSINE_LUT_ARB_STATS_EN
    for (int i = 0; i < 70000; i++) q[0].push_back(i % 64);
    drain(71000);
    check("t6_saturated", 64'(grant_count[15:0]), 64'(16'hFFFF));
    q[0].push_back(9);
    tick();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("t6_clear_wins", 64'(grant_count[15:0]), 64'(0));
    drain(200);
`else
    q[0].push_back(4);
    q[1].push_back(4);
    drain(200);
    check("t6_no_stats", 64'(grant_count), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cosine_lut_arbiter.md
# cosine_lut_arbiter

Round-robin arbiter that shares one single-read-port cosine ROM between several requesters (modulator carrier, demodulator NCO I and Q arms, and so on). It replaces per-consumer LUT copies or the multi-port LUT build. Each requester gets a valid/ready request channel and a held response register. The design accepts one lookup per clock at full throughput, with a bounded wait for every requester.

## Interface
- REQUESTERS, default 3: number of request channels; must be at least 2.
- ANGLE_WIDTH, default $clog2(`CARRIER_SAMPLES_PER_PERIOD): width of the angle/address in steps.
- DATA_WIDTH, default `FIXDT_64_A_WIDTH: signed sample width.

- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  REQUESTERS  per-channel request valid.
- req_angle  in  REQUESTERS*ANGLE_WIDTH  per-channel angle; channel k occupies bits [k*ANGLE_WIDTH +: ANGLE_WIDTH].
- req_ready  out  REQUESTERS  one-hot or zero; request k is accepted when req_valid[k] and req_ready[k] are both high.
- rsp_valid  out  REQUESTERS  one-cycle pulse for channel k when its lookup result is loaded.
- rsp_data  out  REQUESTERS*DATA_WIDTH  signed, per-channel held result.
- rom_en  out  1  ROM read enable (registered).
- rom_addr  out  ANGLE_WIDTH  ROM address (registered).
- rom_data  in  DATA_WIDTH  ROM output; valid one cycle after rom_en.
- stats_clr  in  1  clears the grant counters (see Configuration).
- grant_count  out  REQUESTERS*16  per-channel grant counters (see Configuration).

## Operation
- **Round-robin pointer** `ptr` (range 0..REQUESTERS-1):
  - Each cycle, grant the first k with req_valid[k] high, searching from ptr upward with wrap-around.
  - req_ready[k] is asserted combinationally for that k only. It is 0 for every channel when no request is valid.
- **Pointer update on acceptance:** ptr becomes (granted k + 1) mod REQUESTERS. With no acceptance, ptr holds.
- **Fairness:** a channel that holds req_valid high is accepted within REQUESTERS cycles. Once asserted, req_valid must stay high with a stable angle until the request is accepted.
- **Pipeline, per acceptance in cycle T:**
  - Stage A (visible T+1): rom_en=1, rom_addr=angle, tag=k.
  - Stage B (visible T+2): rom_data is valid, and the tag is carried alongside.
  - Stage C (visible T+3): rsp_data[k] <= rom_data, and rsp_valid[k] pulses for one cycle.
- **No stalls:** the pipeline never stalls, and responses are not back-pressured.
- **Angle handling:** the angle is used unmodified as the address. Wrap-around is the consumer's modulo-2^ANGLE_WIDTH arithmetic, and the arbiter does no range checking.
- **Held data:** rsp_data[k] keeps its value until the next response for k. Other channels' responses never disturb it.
- **Idle cycles:** rom_en is 0, and rom_addr holds its last value.

## Timing
- **Reset values:** req_ready=0 while rst_n is low, rom_en=0, rom_addr=0, rsp_valid=0, rsp_data=0, ptr=0, all pipeline valid/tag bits cleared, grant_count=0.
- **Latency:** 3 cycles from acceptance to rsp_valid.
- **Throughput:** 1 lookup per clock aggregate. With R channels continuously valid, each channel gets 1 lookup per R clocks.
- **Simultaneous requests:** exactly one acceptance per cycle. The losers keep req_valid high and wait.
- **Single active channel:** a channel requesting alone is accepted every cycle, so it gets back-to-back responses.
- **Reset mid-operation:** in-flight lookups are dropped, and no rsp_valid is emitted for them after reset. Requesters must reissue.
- **Outputs driven from flops:** rom_en, rom_addr, rsp_valid and rsp_data. req_ready is combinational from req_valid and ptr.

## Configuration
- **Macro:** COSINE_LUT_ARB_STATS_EN.
- **Defined:**
  - grant_count[k] increments on every acceptance for channel k and saturates at 16'hFFFF.
  - stats_clr=1 zeroes all counters in the next cycle, taking priority over an increment in the same cycle.
- **Undefined:** the ports remain, grant_count is tied to 0, stats_clr is ignored, and no counter flops are built.

## Test plan
1. **Single channel streaming:** after reset, ch0 streams angles 0, 1, 2, … continuously. Expect rsp_valid[0] every cycle starting 3 cycles after the first acceptance, with rsp_data[0] equal to cos_lut(n), while ch1 and ch2 stay at 0.
2. **All channels contending:** all 3 channels hold req_valid from cycle 0 after reset. Expect grants in order 0, 1, 2, 0, 1, 2, … and each channel's rsp_valid spaced exactly 3 cycles apart.
3. **Wrap-around:** ch2 requests angle 2^ANGLE_WIDTH-1 and then angle 0. Expect rom_addr to show 2^ANGLE_WIDTH-1 and then 0, with the matching ROM values on rsp_data[2].
4. **Reset mid-operation:** assert rst_n=0 for 1 cycle at T+1 after an acceptance at T. Expect no rsp_valid at T+3, all outputs at their reset values, and ptr back at 0 (ch0 wins the next contended cycle).
5. **Held data and fairness:** ch1 gets one response, then ch0 and ch2 are hammered for 100 cycles. Expect rsp_data[1] unchanged throughout, and neither ch0 nor ch2 ever waiting more than 3 cycles.
6. **Stats, built with COSINE_LUT_ARB_STATS_EN:**
   - 70000 accepts on ch0: grant_count[0] = 16'hFFFF.
   - stats_clr pulse coincident with an accept: next cycle grant_count[0] = 0.
   - Built without the macro: grant_count stays at 0 throughout.
